mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port access arbiter and sequencer for the Simplez 512×12 main memory. It shares the single memory port between the CPU datapath and the host loader/debug port. It serialises their requests into one-word memory cycles and returns read data with an acknowledge pulse. It sits between both requesters and the memory block: it drives the memory address, write strobe and write data, and samples the memory's registered read data.

## Interface
- `AW`, default 9: address width in bits.
- `DW`, default 12: word width in bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; held with `cpu_req`.
- `cpu_addr`  in  AW  CPU word address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse to the CPU.
- `cpu_rdata`  out  DW  word read from memory, valid while `cpu_ack`=1.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_rdata`: identical set for the loader port.
- `mem_addr`  out  AW  memory address.
- `mem_wr`  out  1  memory write strobe.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data. The memory updates it on the falling edge of `clk` from the address it is presented.
- `busy`  out  1  high when the state machine is not in IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any `*_req`=1, run the picker, latch the winner's ID, we, addr and wdata, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS: `mem_addr`/`mem_wdata` come from the latched request. `mem_wr` = latched we. Next state is RESP.
- RESP:
  - `mem_wr`=0.
  - Capture `mem_rdata` into the winner's `*_rdata` and pulse the winner's `*_ack` for exactly one cycle.
  - Next state is IDLE.
- Write transactions also return data. `*_rdata` carries the word stored at the address *before* the write, because the memory reads before it writes.
- Requester rule: a requester drops `req` on the edge where it samples `ack`=1. A `req` still high in the cycle after ack is treated as a new request.
- The loser of a simultaneous request keeps `req` high. It is served in the next IDLE.
- The loser's `*_ack` stays 0. Its `*_rdata` holds its previous value.
- Request inputs are ignored outside IDLE. A request that arrives mid-transaction waits.

## Timing
- Reset values:
  - state = IDLE.
  - `cpu_ack`, `ldr_ack`, `mem_wr`, `busy` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `cpu_rdata` = 0, `ldr_rdata` = 0.
  - Round-robin pointer = "loader last".
- Latency, with request sampled in IDLE at edge N:
  - ACCESS in cycle N+1. The memory acts on the falling edge in mid-cycle N+1.
  - `ack` is high in cycle N+2.
  - IDLE again in cycle N+3.
- Fixed 3-cycle round trip; maximum throughput is one word per 3 cycles.
- All outputs are registered; there is no combinational path from request inputs to memory outputs.
- Reset asserted during ACCESS:
  - `mem_wr` clears immediately.
  - The write is lost if reset arrives before that cycle's falling edge.
  - No `ack` is ever issued for an aborted transaction.
- Reset released: the first request is accepted on the first rising edge with `rstn`=1.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: simultaneous requests go to the port not granted last. The pointer updates on every grant; after reset the CPU wins the first tie.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, CPU always wins a tie. The pointer register is not instantiated.
- A single, non-contended requester behaves identically in both builds.

## Structure
- Shared package `simplez_pkg`:
  - `AW`/`DW` constants.
  - State enum {IDLE, ACCESS, RESP}.
  - Requester ID constants `REQ_CPU`=0 and `REQ_LDR`=1.
- One natural sub-module, `mem_arb_pick`: a combinational picker that takes the two reqs and the last-grant pointer and returns the winner ID. The macro selects its policy.

## Test plan
- CPU read of addr 0o006 (contents 0o0001), loader idle -> `mem_wr` never high. `cpu_ack` in cycle N+2 with `cpu_rdata`=0o0001. `ldr_ack` stays 0.
- Loader write 0o4321 to addr 0o100 (old contents 0o0000), then CPU read of 0o100 -> loader ack returns 0o0000. `mem_wr` high in exactly one cycle. The CPU read returns 0o4321.
- Both ports request reads in the same cycle, held continuously:
  - Without macro: CPU acked first, loader acked 3 cycles later.
  - With macro: the next tie goes to the loader.
- CPU holds `req` for 4 back-to-back reads of 0o003–0o006 -> acks spaced exactly 3 cycles apart, data 0o0003, 0o0004, 0o0005, 0o0001. `busy` drops for one cycle between transactions.
- Loader write asserted, `rstn` pulsed low mid-ACCESS before the falling edge -> all outputs at reset values immediately. Target word unchanged, no ack.
- Request raised during RESP of another transaction -> ignored until IDLE, then served with the normal 3-cycle latency.

Source files
------------

// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez memory subsystem: word/address widths,
// arbiter state encoding and requester IDs.
package simplez_pkg;

    localparam int AW = 9;
    localparam int DW = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner picker for the two-port memory arbiter.
// MEM_ARB_ROUND_ROBIN_EN defined: a tie goes to the port not granted last.
// MEM_ARB_ROUND_ROBIN_EN undefined: the CPU always wins a tie.
module mem_arb_pick
    import simplez_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic last,
    output logic win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round-robin: on a tie, favour whichever port was not served last.
    always_comb begin
        win = REQ_CPU;
        if (cpu_req && ldr_req) begin
            win = (last == REQ_CPU) ? REQ_LDR : REQ_CPU;
        end else if (ldr_req) begin
            win = REQ_LDR;
        end
    end
`else
    // Fixed priority ignores the last-grant pointer.
    logic unused_last;
    assign unused_last = last;

    // Fixed priority: the loader only wins when the CPU is not asking.
    always_comb begin
        win = REQ_CPU;
        if (ldr_req && !cpu_req) begin
            win = REQ_LDR;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the Simplez 512x12 main memory.
// Serialises CPU and loader requests into one-word cycles:
// IDLE -> ACCESS (memory acts on the falling edge) -> RESP (ack + data).
// Optional round-robin tie-break: define MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import simplez_pkg::*;
#(
    parameter int AW = simplez_pkg::AW,
    parameter int DW = simplez_pkg::DW
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    state_t state;
    logic   win;
    logic   id;
    logic   last_grant;

    mem_arb_pick u_pick (
        .cpu_req (cpu_req),
        .ldr_req (ldr_req),
        .last    (last_grant),
        .win     (win)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember the port granted most recently; reset state makes the CPU win the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= REQ_LDR;
        end else if (state == IDLE && (cpu_req || ldr_req)) begin
            last_grant <= win;
        end
    end
`else
    assign last_grant = REQ_LDR;
`endif

    // Transaction sequencer: latch the winner in IDLE, strobe memory in ACCESS,
    // return the pre-write word with a one-cycle ack in RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            id        <= REQ_CPU;
            mem_addr  <= '0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                    if (cpu_req || ldr_req) begin
                        id        <= win;
                        mem_addr  <= (win == REQ_LDR) ? ldr_addr  : cpu_addr;
                        mem_wr    <= (win == REQ_LDR) ? ldr_we    : cpu_we;
                        mem_wdata <= (win == REQ_LDR) ? ldr_wdata : cpu_wdata;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_rdata was refreshed on this cycle's falling edge.
                    mem_wr <= 1'b0;
                    state  <= RESP;
                    if (id == REQ_LDR) begin
                        ldr_rdata <= mem_rdata;
                        ldr_ack   <= 1'b1;
                    end else begin
                        cpu_rdata <= mem_rdata;
                        cpu_ack   <= 1'b1;
                    end
                end
                RESP: begin
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                    mem_wr  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single-port transactions
// plus hand-written tie, back-to-back, late-request and reset sequences.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          ldr_req = 1'b0, ldr_we = 1'b0;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .ldr_rdata (ldr_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory model: read-before-write on the falling edge.
    logic [DW-1:0] mem [0:511];
    always @(negedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    int total  = 0;
    int passed = 0;
    logic [DW-1:0] hold_cpu = '0;
    logic [DW-1:0] hold_ldr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0o, expected %0o", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          ldr;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    // One isolated transaction from IDLE, checked cycle by cycle.
    task automatic run_vec(input int i, input vec_t v);
        if (v.ldr) begin
            ldr_req = 1'b1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wd;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wd;
        end
        tick;
        check($sformatf("row%0d busy_access", i), busy, 1);
        check($sformatf("row%0d mem_wr_access", i), mem_wr, v.we);
        check($sformatf("row%0d mem_addr", i), mem_addr, v.addr);
        if (v.we) check($sformatf("row%0d mem_wdata", i), mem_wdata, v.wd);
        tick;
        check($sformatf("row%0d mem_wr_resp", i), mem_wr, 0);
        if (v.ldr) begin
            check($sformatf("row%0d ldr_ack", i), ldr_ack, 1);
            check($sformatf("row%0d cpu_ack", i), cpu_ack, 0);
            check($sformatf("row%0d ldr_rdata", i), ldr_rdata, v.exp_rd);
            check($sformatf("row%0d cpu_rdata_hold", i), cpu_rdata, hold_cpu);
            hold_ldr = v.exp_rd;
            ldr_req = 1'b0;
        end else begin
            check($sformatf("row%0d cpu_ack", i), cpu_ack, 1);
            check($sformatf("row%0d ldr_ack", i), ldr_ack, 0);
            check($sformatf("row%0d cpu_rdata", i), cpu_rdata, v.exp_rd);
            check($sformatf("row%0d ldr_rdata_hold", i), ldr_rdata, hold_ldr);
            hold_cpu = v.exp_rd;
            cpu_req = 1'b0;
        end
        tick;
        check($sformatf("row%0d acks_clear", i), {cpu_ack, ldr_ack}, 0);
        check($sformatf("row%0d busy_idle", i), busy, 0);
    endtask

    // Both ports read together (cpu 0o003, ldr 0o004); loser served 3 cycles later.
    task automatic tie(input string tag, input logic ldr_first);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'o003;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'o004;
        tick;
        check({tag, " first_addr"}, mem_addr, ldr_first ? 9'o004 : 9'o003);
        tick;
        check({tag, " first_cpu_ack"}, cpu_ack, !ldr_first);
        check({tag, " first_ldr_ack"}, ldr_ack, ldr_first);
        if (ldr_first) begin
            check({tag, " first_data"}, ldr_rdata, 12'o0004);
            check({tag, " loser_hold"}, cpu_rdata, hold_cpu);
            ldr_req = 1'b0; hold_ldr = 12'o0004;
        end else begin
            check({tag, " first_data"}, cpu_rdata, 12'o0003);
            check({tag, " loser_hold"}, ldr_rdata, hold_ldr);
            cpu_req = 1'b0; hold_cpu = 12'o0003;
        end
        tick;
        tick;
        check({tag, " second_busy"}, busy, 1);
        check({tag, " second_addr"}, mem_addr, ldr_first ? 9'o003 : 9'o004);
        tick;
        check({tag, " second_cpu_ack"}, cpu_ack, ldr_first);
        check({tag, " second_ldr_ack"}, ldr_ack, !ldr_first);
        if (ldr_first) begin
            check({tag, " second_data"}, cpu_rdata, 12'o0003);
            cpu_req = 1'b0; hold_cpu = 12'o0003;
        end else begin
            check({tag, " second_data"}, ldr_rdata, 12'o0004);
            ldr_req = 1'b0; hold_ldr = 12'o0004;
        end
        tick;
    endtask

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = '0;
        mem[9'o003] = 12'o0003;
        mem[9'o004] = 12'o0004;
        mem[9'o005] = 12'o0005;
        mem[9'o006] = 12'o0001;

        //          ldr   we    addr    wdata    expected rdata
        vecs[0] = '{1'b0, 1'b0, 9'o006, 12'o0,    12'o0001};
        vecs[1] = '{1'b1, 1'b1, 9'o100, 12'o4321, 12'o0000};
        vecs[2] = '{1'b0, 1'b0, 9'o100, 12'o0,    12'o4321};
        vecs[3] = '{1'b0, 1'b1, 9'o010, 12'o7777, 12'o0000};
        vecs[4] = '{1'b0, 1'b0, 9'o010, 12'o0,    12'o7777};
        vecs[5] = '{1'b1, 1'b0, 9'o010, 12'o0,    12'o7777};
        vecs[6] = '{1'b1, 1'b1, 9'o100, 12'o0055, 12'o4321};
        vecs[7] = '{1'b0, 1'b0, 9'o100, 12'o0,    12'o0055};

        // Reset state
        #2 rstn = 1'b0;
        tick;
        tick;
        check("reset busy", busy, 0);
        check("reset mem_wr", mem_wr, 0);
        check("reset acks", {cpu_ack, ldr_ack}, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset rdata", {cpu_rdata, ldr_rdata}, 0);
        #3 rstn = 1'b1;
        tick;

        // First tie after reset: CPU wins in both builds
        tie("tie1", 1'b0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Last grant was the CPU: round-robin hands this tie to the loader
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie("tie2", 1'b1);
`else
        tie("tie2", 1'b0);
`endif

        // Back-to-back CPU reads with req held high
        begin
            logic [DW-1:0] b2b_exp [4];
            b2b_exp = '{12'o0003, 12'o0004, 12'o0005, 12'o0001};
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'o003;
            for (int k = 0; k < 4; k++) begin
                int w;
                w = 0;
                do begin
                    tick;
                    w++;
                end while (!cpu_ack && w < 12);
                check($sformatf("b2b%0d ack", k), cpu_ack, 1);
                check($sformatf("b2b%0d spacing", k), w, 2);
                check($sformatf("b2b%0d data", k), cpu_rdata, b2b_exp[k]);
                if (k < 3) cpu_addr = 9'(9'o003 + k + 1);
                else cpu_req = 1'b0;
                tick;
                check($sformatf("b2b%0d busy_gap", k), busy, 0);
            end
            hold_cpu = 12'o0001;
        end

        // Loader request raised during RESP of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'o003;
        tick;
        tick;
        check("late cpu_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 9'o004;
        tick;
        check("late ignored_busy", busy, 0);
        check("late ignored_ack", ldr_ack, 0);
        tick;
        check("late accepted_busy", busy, 1);
        check("late accepted_addr", mem_addr, 9'o004);
        tick;
        check("late ldr_ack", ldr_ack, 1);
        check("late ldr_data", ldr_rdata, 12'o0004);
        ldr_req = 1'b0;
        tick;

        // Reset pulsed mid-ACCESS before the falling edge
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 9'o020; ldr_wdata = 12'o1234;
        tick;
        check("abort mem_wr_before", mem_wr, 1);
        #1 rstn = 1'b0;
        #1;
        check("abort mem_wr", mem_wr, 0);
        check("abort busy", busy, 0);
        check("abort mem_addr", mem_addr, 0);
        check("abort mem_wdata", mem_wdata, 0);
        check("abort rdata", {cpu_rdata, ldr_rdata}, 0);
        check("abort acks", {cpu_ack, ldr_ack}, 0);
        ldr_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'o020;
        #5 rstn = 1'b1;
        tick;
        check("post_reset first_edge_busy", busy, 1);
        check("post_reset ldr_ack", ldr_ack, 0);
        tick;
        check("post_reset cpu_ack", cpu_ack, 1);
        check("post_reset cpu_data", cpu_rdata, 12'o0000);
        check("post_reset no_ldr_ack", ldr_ack, 0);
        cpu_req = 1'b0;
        tick;
        check("abort target_unchanged", mem[9'o020], 12'o0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
